// File: rtl/intpol2_d4_pkg.sv
// Shared types and constants for the quadratic D4 interpolator control path.
package intpol2_d4_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_M = 3'd1,
        WAIT   = 3'd2,
        RUN    = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int unsigned D_FACTOR     = 4;
    localparam int unsigned PHASE_W      = 2;
    localparam int unsigned PIPE_LAT_DEF = 3;
    localparam int unsigned PIPE_LAT_MIN = 1;
    localparam int unsigned PIPE_LAT_MAX = 8;
    localparam int unsigned DRAIN_W      = $clog2(PIPE_LAT_MAX + 1);

endpackage

// File: rtl/intpol2_d4_lat_pipe.sv
// Single-bit DEPTH-stage delay line with synchronous flush; turns en_sum into Write_Enable.
module intpol2_d4_lat_pipe #(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic rstn,
    input  logic flush,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)      sr <= '0;
                else if (flush) sr <= '0;
                else            sr <= din;
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn)      sr <= '0;
                else if (flush) sr <= '0;
                else            sr <= {sr[DEPTH-2:0], din};
            end
        end
    endgenerate

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/intpol2_d4_ctrl_fsm.sv
// Control sequencer for the D4 quadratic interpolator: preload, run, drain, done.
// Optional sticky done interrupt enabled by defining INTPOL2_D4_IRQ_EN.
module intpol2_d4_ctrl_fsm
    import intpol2_d4_pkg::*;
#(
    parameter int unsigned CONFIG_WIDTH = 32,
    parameter int unsigned PIPE_LAT     = PIPE_LAT_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear,
    input  logic                    start,
    input  logic [CONFIG_WIDTH-1:0] ilen,
    input  logic                    Empty,
    input  logic                    Afull,
    input  logic                    comp_addr,
    input  logic                    comp_cnt,
    output logic                    busy,
    output logic                    en_M_addr,
    output logic                    en_sum,
    output logic                    Read_Enable,
    output logic                    Write_Enable,
    output logic                    done,
    output logic                    stall,
    output logic                    irq,
    input  logic                    irq_clr
);

    state_t               state, state_nxt;
    logic [PHASE_W-1:0]   phase, phase_nxt;
    logic [DRAIN_W-1:0]   drain_cnt, drain_nxt;
    logic                 busy_nxt, en_m_nxt, done_nxt;
    logic                 blocked;

    // State, phase, drain counter and Moore outputs (registered from next state).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            phase     <= '0;
            drain_cnt <= '0;
            busy      <= 1'b0;
            en_M_addr <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            drain_cnt <= drain_nxt;
            busy      <= busy_nxt;
            en_M_addr <= en_m_nxt;
            done      <= done_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        phase_nxt   = phase;
        drain_nxt   = drain_cnt;
        en_sum      = 1'b0;
        Read_Enable = 1'b0;
        stall       = 1'b0;
        blocked     = Afull || ((phase == '0) && Empty);

        unique case (state)
            IDLE: begin
                if (start) state_nxt = (ilen != '0) ? LOAD_M : DONE;
            end
            LOAD_M: begin
                if (comp_addr) state_nxt = WAIT;
            end
            WAIT: begin
                if (!Empty && !Afull) state_nxt = RUN;
            end
            RUN: begin
                if (blocked) begin
                    stall = 1'b1;
                end else begin
                    en_sum      = 1'b1;
                    Read_Enable = (phase == '0);
                    phase_nxt   = phase + PHASE_W'(1);
                    if (comp_cnt) begin
                        state_nxt = DRAIN;
                        drain_nxt = DRAIN_W'(PIPE_LAT);
                    end
                end
            end
            DRAIN: begin
                drain_nxt = drain_cnt - DRAIN_W'(1);
                if (drain_cnt == DRAIN_W'(1)) state_nxt = DONE;
            end
            DONE: begin
                phase_nxt = '0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Soft abort overrides everything, including this cycle's combinational strobes.
        if (clear) begin
            state_nxt   = IDLE;
            phase_nxt   = '0;
            drain_nxt   = '0;
            en_sum      = 1'b0;
            Read_Enable = 1'b0;
            stall       = 1'b0;
        end

        busy_nxt = (state_nxt != IDLE);
        en_m_nxt = (state_nxt == LOAD_M);
        done_nxt = (state_nxt == DONE);
    end

    intpol2_d4_lat_pipe #(
        .DEPTH (PIPE_LAT)
    ) u_lat_pipe (
        .clk   (clk),
        .rstn  (rstn),
        .flush (clear),
        .din   (en_sum),
        .dout  (Write_Enable)
    );

`ifdef INTPOL2_D4_IRQ_EN
    // Sticky interrupt; the set term covers the whole done cycle so it beats irq_clr.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                 irq <= 1'b0;
        else if (clear)            irq <= 1'b0;
        else if (done_nxt || done) irq <= 1'b1;
        else if (irq_clr)          irq <= 1'b0;
    end
`else
    logic unused_irq_clr;
    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_intpol2_d4_ctrl_fsm.sv
// Directed self-checking bench for intpol2_d4_ctrl_fsm; models the next-state logic handshakes.
module tb_intpol2_d4_ctrl_fsm;
    import intpol2_d4_pkg::*;

    localparam int unsigned CW = 32;
    localparam int unsigned PL = 3;
`ifdef INTPOL2_D4_IRQ_EN
    localparam logic [31:0] IRQ_ON = 32'd1;
`else
    localparam logic [31:0] IRQ_ON = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rstn, clear, start, Empty, Afull, irq_clr;
    logic          comp_addr = 1'b0;
    logic          comp_cnt  = 1'b0;
    logic [CW-1:0] ilen;
    logic          busy, en_M_addr, en_sum, Read_Enable, Write_Enable, done, stall, irq;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_m, n_sum, n_rd, n_we, n_stall, n_done;
    int first_sum, last_sum, first_we, last_we, done_cyc;
    int rd_at[4];
    int job_len = 0;
    int start_cyc, clear_cyc;

    intpol2_d4_ctrl_fsm #(
        .CONFIG_WIDTH (CW),
        .PIPE_LAT     (PL)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .clear        (clear),
        .start        (start),
        .ilen         (ilen),
        .Empty        (Empty),
        .Afull        (Afull),
        .comp_addr    (comp_addr),
        .comp_cnt     (comp_cnt),
        .busy         (busy),
        .en_M_addr    (en_M_addr),
        .en_sum       (en_sum),
        .Read_Enable  (Read_Enable),
        .Write_Enable (Write_Enable),
        .done         (done),
        .stall        (stall),
        .irq          (irq),
        .irq_clr      (irq_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor; also plays the next-state logic (M2 loaded after 3 pulses, last sum).
    always @(negedge clk) begin
        if (rstn) begin
            if (en_M_addr) n_m++;
            if (en_sum) begin
                if (n_sum == 0) first_sum = cyc;
                last_sum = cyc;
                n_sum++;
            end
            if (Read_Enable) begin
                if (n_rd < 4) rd_at[n_rd] = n_sum;
                n_rd++;
            end
            if (Write_Enable) begin
                if (n_we == 0) first_we = cyc;
                last_we = cyc;
                n_we++;
            end
            if (stall) n_stall++;
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
        comp_addr = (n_m >= 3);
        comp_cnt  = (job_len != 0) && (n_sum >= job_len);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        n_m = 0; n_sum = 0; n_rd = 0; n_we = 0; n_stall = 0; n_done = 0;
        first_sum = -1; last_sum = -1; first_we = -1; last_we = -1; done_cyc = -1;
        for (int i = 0; i < 4; i++) rd_at[i] = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int len, input int hold);
        clr_mon();
        job_len   = len;
        ilen      = CW'(len);
        start     = 1'b1;
        start_cyc = cyc;
        repeat (hold) tick();
        start = 1'b0;
    endtask

    task automatic wait_sums(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (n_sum >= n) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("sum_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input logic clr_at_done);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (done) begin
                irq_clr = clr_at_done;
                ok = 1'b1;
                break;
            end
        end
        check("done_timeout", 32'(ok), 32'd1);
        tick();
        irq_clr = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; clear = 1'b0; start = 1'b0; Empty = 1'b0; Afull = 1'b0;
        irq_clr = 1'b0; ilen = '0;
        clr_mon();
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", 32'({busy, en_M_addr, en_sum, Read_Enable, Write_Enable, done, stall, irq}), 32'd0);
        rstn = 1'b1;
        tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Basic 8-sample job.
        start_job(8, 1);
        wait_done(1'b0);
        check("basic_m_addr", 32'(n_m), 32'd3);
        check("basic_sums", 32'(n_sum), 32'd8);
        check("basic_sum_span", 32'(last_sum - first_sum), 32'd7);
        check("basic_reads", 32'(n_rd), 32'd2);
        check("basic_rd0_at", 32'(rd_at[0]), 32'd1);
        check("basic_rd1_at", 32'(rd_at[1]), 32'd5);
        check("basic_writes", 32'(n_we), 32'd8);
        check("basic_we_lat", 32'(first_we - first_sum), 32'd3);
        check("basic_last_we", 32'(last_we - last_sum), 32'd3);
        check("basic_done_after_we", 32'(done_cyc - last_we), 32'd1);
        check("basic_done_cnt", 32'(n_done), 32'd1);
        check("basic_stalls", 32'(n_stall), 32'd0);
        check("basic_busy_end", 32'(busy), 32'd0);
        check("basic_irq", 32'(irq), IRQ_ON);

        // Isolated irq_clr.
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("irq_clr_iso", 32'(irq), 32'd0);

        // Empty stall when phase returns to 0; irq_clr coincident with done.
        start_job(8, 1);
        wait_sums(4);
        Empty = 1'b1;
        repeat (5) tick();
        Empty = 1'b0;
        wait_done(1'b1);
        check("empty_stalls", 32'(n_stall), 32'd5);
        check("empty_sums", 32'(n_sum), 32'd8);
        check("empty_reads", 32'(n_rd), 32'd2);
        check("empty_rd1_at", 32'(rd_at[1]), 32'd5);
        check("empty_writes", 32'(n_we), 32'd8);
        check("empty_sum_span", 32'(last_sum - first_sum), 32'd12);
        check("irq_set_wins", 32'(irq), IRQ_ON);
        repeat (3) tick();
        check("irq_holds", 32'(irq), IRQ_ON);

        // Afull stall in phase 2.
        start_job(6, 1);
        wait_sums(2);
        Afull = 1'b1;
        repeat (2) tick();
        Afull = 1'b0;
        wait_done(1'b0);
        check("afull_stalls", 32'(n_stall), 32'd2);
        check("afull_sums", 32'(n_sum), 32'd6);
        check("afull_reads", 32'(n_rd), 32'd2);
        check("afull_rd1_at", 32'(rd_at[1]), 32'd5);
        check("afull_writes", 32'(n_we), 32'd6);
        check("afull_sum_span", 32'(last_sum - first_sum), 32'd7);

        // Zero-length job; start still high in the DONE cycle must be ignored.
        start_job(0, 2);
        repeat (6) tick();
        check("zero_done_cnt", 32'(n_done), 32'd1);
        check("zero_done_cyc", 32'(done_cyc - start_cyc), 32'd1);
        check("zero_activity", 32'(n_m + n_sum + n_rd + n_we), 32'd0);
        check("zero_busy_end", 32'(busy), 32'd0);

        // Soft abort after 3 sums.
        start_job(8, 1);
        wait_sums(3);
        clear     = 1'b1;
        clear_cyc = cyc;
        tick();
        clear = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_we_next", 32'(Write_Enable), 32'd0);
        repeat (8) tick();
        check("abort_sums", 32'(n_sum), 32'd3);
        check("abort_last_we", 32'(last_we - clear_cyc), 32'd0);
        check("abort_writes", 32'(n_we), 32'd1);
        check("abort_no_done", 32'(n_done), 32'd0);

        // Clean job after abort.
        start_job(8, 1);
        wait_done(1'b0);
        check("post_abort_m", 32'(n_m), 32'd3);
        check("post_abort_sums", 32'(n_sum), 32'd8);
        check("post_abort_reads", 32'(n_rd), 32'd2);
        check("post_abort_writes", 32'(n_we), 32'd8);
        check("post_abort_lat", 32'(first_we - first_sum), 32'd3);

        // Async reset mid-DRAIN.
        start_job(4, 1);
        wait_sums(4);
        #2;
        check("drain_we_pre", 32'(Write_Enable), 32'd1);
        check("drain_busy_pre", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        check("async_rst_outs", 32'({busy, en_M_addr, en_sum, Read_Enable, Write_Enable, done, stall, irq}), 32'd0);
        tick();
        rstn = 1'b1;
        repeat (5) tick();
        check("after_rst_busy", 32'(busy), 32'd0);
        check("after_rst_done", 32'(n_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
